// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants, colour type and pixel helpers
// used by the VGA scan engine and its axis counters.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    typedef logic [5:0] color_t;
    localparam color_t COLOR_BLACK = 6'h00;

    // Overlay wins over background; anything outside the visible area is black.
    function automatic color_t composite(input logic act, input logic draw,
                                         input color_t fg, input color_t bg);
        if (!act) begin
            composite = COLOR_BLACK;
        end else if (draw) begin
            composite = fg;
        end else begin
            composite = bg;
        end
    endfunction

    function automatic logic in_window(input logic [COORD_W-1:0] v,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        in_window = (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping raster axis counter: counts 0..TOTAL-1 while enabled and flags
// the last position so the next axis can be advanced.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = VGA_H_TOTAL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    output logic [COORD_W-1:0] o_count,
    output logic               o_wrap
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

    logic [COORD_W-1:0] r_count;

    assign o_count = r_count;
    assign o_wrap  = (r_count == LAST);

    // Position register; reset returns the axis to zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {COORD_W{1'b0}};
        end else if (i_en) begin
            r_count <= o_wrap ? {COORD_W{1'b0}} : r_count + 10'd1;
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/vga_scan_engine.sv
// VGA raster engine: x/y scan, active/next_frame decode, overlay compositing and
// a registered sync/colour output stage. Optional macro VGA_SCAN_PIXDIV_EN runs clk at 2x pixel rate.
module vga_scan_engine
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fg_draw,
    input  color_t             fg_rgb,
    input  color_t             bg_rgb,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               next_frame,
    output logic               pix_tick,
    output logic               hsync,
    output logic               vsync,
    output color_t             rgb_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_ACT_L = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_L = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_LO   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_HI   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_LO   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_HI   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic               w_pix_tick;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               w_active;

    logic               r_hsync;
    logic               r_vsync;
    color_t             r_rgb;

`ifdef VGA_SCAN_PIXDIV_EN
    logic r_pix_div;

    // Divide-by-two pixel enable: low out of reset, first high on the 2nd clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_div <= 1'b0;
        end else begin
            r_pix_div <= ~r_pix_div;
        end
    end

    assign w_pix_tick = r_pix_div;
`else
    assign w_pix_tick = 1'b1;
`endif

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_pix_tick),
        .o_count (w_x),
        .o_wrap  (w_h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_pix_tick & w_h_wrap),
        .o_count (w_y),
        .o_wrap  (w_v_wrap)
    );

    assign w_active = (w_x < H_ACT_L) && (w_y < V_ACT_L);

    // Output stage: colour and syncs for the current x/y land together one pixel later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_rgb   <= COLOR_BLACK;
        end else if (w_pix_tick) begin
            r_hsync <= in_window(w_x, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
            r_vsync <= in_window(w_y, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
            r_rgb   <= composite(w_active, fg_draw, fg_rgb, bg_rgb);
        end else begin
            r_hsync <= r_hsync;
            r_vsync <= r_vsync;
            r_rgb   <= r_rgb;
        end
    end

    assign x          = w_x;
    assign y          = w_y;
    assign active     = w_active;
    assign pix_tick   = w_pix_tick;
    assign next_frame = (w_x == 10'd0) && (w_y == V_ACT_L) && w_pix_tick;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign rgb_out    = r_rgb;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Self-checking bench: a full-size 640x480 engine and a shrunken one with
// positive sync polarity, both checked every cycle against a pixel-count model.
module tb_vga_scan_engine;

    localparam int P_HA  [2] = '{640, 16};
    localparam int P_HFP [2] = '{16, 2};
    localparam int P_HS  [2] = '{96, 4};
    localparam int P_HBP [2] = '{48, 3};
    localparam int P_VA  [2] = '{480, 8};
    localparam int P_VFP [2] = '{10, 2};
    localparam int P_VS  [2] = '{2, 2};
    localparam int P_VBP [2] = '{33, 3};
    localparam bit P_POL [2] = '{1'b0, 1'b1};
    localparam int BUDGET = 60000;

    logic       clk;
    logic       rst;
    logic       i_fgd [2];
    logic [5:0] i_fg  [2];
    logic [5:0] i_bg  [2];
    logic [9:0] o_x   [2];
    logic [9:0] o_y   [2];
    logic       o_act [2];
    logic       o_nf  [2];
    logic       o_tick[2];
    logic       o_hs  [2];
    logic       o_vs  [2];
    logic [5:0] o_rgb [2];

    int n_chk  = 0;
    int n_pass = 0;

    // behavioural model state: pixels elapsed since reset and the expected registered stage
    int         n   [2];
    int         lx  [2];
    int         ly  [2];
    logic [5:0] e_rgb[2];
    logic       e_hs[2];
    logic       e_vs[2];
    int         ecnt;
    bit         ticked;

    vga_scan_engine u_dut0 (
        .clk(clk), .rst(rst), .fg_draw(i_fgd[0]), .fg_rgb(i_fg[0]), .bg_rgb(i_bg[0]),
        .x(o_x[0]), .y(o_y[0]), .active(o_act[0]), .next_frame(o_nf[0]),
        .pix_tick(o_tick[0]), .hsync(o_hs[0]), .vsync(o_vs[0]), .rgb_out(o_rgb[0])
    );

    vga_scan_engine #(
        .H_ACTIVE(P_HA[1]), .H_FP(P_HFP[1]), .H_SYNC(P_HS[1]), .H_BP(P_HBP[1]),
        .V_ACTIVE(P_VA[1]), .V_FP(P_VFP[1]), .V_SYNC(P_VS[1]), .V_BP(P_VBP[1]),
        .SYNC_POL(P_POL[1])
    ) u_dut1 (
        .clk(clk), .rst(rst), .fg_draw(i_fgd[1]), .fg_rgb(i_fg[1]), .bg_rgb(i_bg[1]),
        .x(o_x[1]), .y(o_y[1]), .active(o_act[1]), .next_frame(o_nf[1]),
        .pix_tick(o_tick[1]), .hsync(o_hs[1]), .vsync(o_vs[1]), .rgb_out(o_rgb[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int htot(input int d);
        return P_HA[d] + P_HFP[d] + P_HS[d] + P_HBP[d];
    endfunction

    function automatic int vtot(input int d);
        return P_VA[d] + P_VFP[d] + P_VS[d] + P_VBP[d];
    endfunction

    function automatic bit tick_now();
`ifdef VGA_SCAN_PIXDIV_EN
        return (ecnt % 2) == 1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    // model: every pixel tick consumes one coordinate and registers its colour/syncs
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                ecnt   = 0;
                ticked = 1'b0;
                for (int d = 0; d < 2; d++) begin
                    n[d] = 0; lx[d] = -1; ly[d] = -1;
                    e_rgb[d] = 6'h00; e_hs[d] = ~P_POL[d]; e_vs[d] = ~P_POL[d];
                end
            end else begin
                ticked = tick_now();
                if (ticked) begin
                    for (int d = 0; d < 2; d++) begin
                        int cx, cy, hs0, vs0;
                        cx  = n[d] % htot(d);
                        cy  = (n[d] / htot(d)) % vtot(d);
                        hs0 = P_HA[d] + P_HFP[d];
                        vs0 = P_VA[d] + P_VFP[d];
                        if (cx < P_HA[d] && cy < P_VA[d]) e_rgb[d] = i_fgd[d] ? i_fg[d] : i_bg[d];
                        else e_rgb[d] = 6'h00;
                        e_hs[d] = (cx >= hs0 && cx < hs0 + P_HS[d]) ? P_POL[d] : ~P_POL[d];
                        e_vs[d] = (cy >= vs0 && cy < vs0 + P_VS[d]) ? P_POL[d] : ~P_POL[d];
                        lx[d] = cx;
                        ly[d] = cy;
                        n[d]  = n[d] + 1;
                    end
                end
                ecnt = ecnt + 1;
            end
        end
    end

    // stimulus: random generator colours, with directed values at chosen pixels of the full-size engine
    initial begin
        for (int d = 0; d < 2; d++) begin
            i_fgd[d] = 1'b0; i_fg[d] = 6'h00; i_bg[d] = 6'h00;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                i_fgd[d] = 1'($urandom);
                i_fg[d]  = 6'($urandom);
                i_bg[d]  = 6'($urandom);
            end
            if ((n[0] / 800) % 525 == 10) begin
                case (n[0] % 800)
                    10:      begin i_fgd[0] = 1'b1; i_fg[0] = 6'h3F; i_bg[0] = 6'h15; end
                    11:      begin i_fgd[0] = 1'b0; i_fg[0] = 6'h3F; i_bg[0] = 6'h15; end
                    700:     begin i_fgd[0] = 1'b1; i_fg[0] = 6'h3F; i_bg[0] = 6'h2A; end
                    default: begin end
                endcase
            end
        end
    end

    // compare process plus hand-computed landmarks
    int h_cnt = 0, h_first = -1, v_cnt = 0, v_first = -1, nf_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int ex, ey;
                ex = n[d] % htot(d);
                ey = (n[d] / htot(d)) % vtot(d);
                chk($sformatf("x%0d", d), 32'(o_x[d]), ex);
                chk($sformatf("y%0d", d), 32'(o_y[d]), ey);
                chk($sformatf("active%0d", d), 32'(o_act[d]), 32'(ex < P_HA[d] && ey < P_VA[d]));
                chk($sformatf("next_frame%0d", d), 32'(o_nf[d]),
                    32'(ex == 0 && ey == P_VA[d] && tick_now()));
                chk($sformatf("pix_tick%0d", d), 32'(o_tick[d]), 32'(tick_now()));
                chk($sformatf("hsync%0d", d), 32'(o_hs[d]), 32'(e_hs[d]));
                chk($sformatf("vsync%0d", d), 32'(o_vs[d]), 32'(e_vs[d]));
                chk($sformatf("rgb%0d", d), 32'(o_rgb[d]), 32'(e_rgb[d]));
            end
            if (rst) begin
                h_cnt = 0; h_first = -1; v_cnt = 0; v_first = -1; nf_cnt = 0;
            end else begin
                if (ticked && ly[0] == 10 && lx[0] == 10) chk("ovl_priority", 32'(o_rgb[0]), 32'h3F);
                if (ticked && ly[0] == 10 && lx[0] == 11) chk("bg_select", 32'(o_rgb[0]), 32'h15);
                if (ticked && ly[0] == 10 && lx[0] == 700) chk("blank_black", 32'(o_rgb[0]), 32'h00);
                if (ticked && ly[0] == 3) begin
                    if (o_hs[0] == 1'b0) begin
                        if (h_cnt == 0) h_first = lx[0];
                        h_cnt = h_cnt + 1;
                    end
                    if (lx[0] == 799) begin
                        chk("hsync_width", h_cnt, 96);
                        chk("hsync_first_x", h_first, 656);
                        h_cnt = 0; h_first = -1;
                    end
                end
                if (ticked) begin
                    if (o_vs[1] == 1'b1) begin
                        if (v_cnt == 0) v_first = ly[1];
                        v_cnt = v_cnt + 1;
                    end
                    if (lx[1] == 24 && ly[1] == 14) begin
                        chk("vsync_pixels", v_cnt, 50);
                        chk("vsync_first_y", v_first, 10);
                        v_cnt = 0; v_first = -1;
                    end
                end
                if (o_nf[1]) begin
                    nf_cnt = nf_cnt + 1;
                    chk("nf_at_x", 32'(o_x[1]), 0);
                    chk("nf_at_y", 32'(o_y[1]), 8);
                end
                if (n[1] % 375 == 374 && tick_now()) begin
                    chk("nf_per_frame", nf_cnt, 1);
                    nf_cnt = 0;
                end
                if (n[1] == 375) begin
                    chk("frame_wrap_x", 32'(o_x[1]), 0);
                    chk("frame_wrap_y", 32'(o_y[1]), 0);
                end
            end
        end
    end

    initial begin
        int cyc;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_x", 32'(o_x[0]), 0);
        chk("rst_y", 32'(o_y[0]), 0);
        chk("rst_active", 32'(o_act[0]), 1);
        chk("rst_rgb", 32'(o_rgb[0]), 0);
        chk("rst_hsync_lo_pol", 32'(o_hs[0]), 1);
        chk("rst_vsync_hi_pol", 32'(o_vs[1]), 0);
        chk("rst_next_frame", 32'(o_nf[0]), 0);
        @(negedge clk);
        rst = 1'b0;

        cyc = 0;
        while (n[0] != 6 * 800 + 700 && cyc < BUDGET) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
        chk("reach_mid_line", 32'(cyc < BUDGET), 1);
        chk("pre_rst_hsync", 32'(o_hs[0]), 0);

        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_x", 32'(o_x[0]), 0);
        chk("midrst_y", 32'(o_y[0]), 0);
        chk("midrst_rgb0", 32'(o_rgb[0]), 0);
        chk("midrst_rgb1", 32'(o_rgb[1]), 0);
        chk("midrst_hsync0", 32'(o_hs[0]), 1);
        chk("midrst_hsync1", 32'(o_hs[1]), 0);
        @(negedge clk);
        rst = 1'b0;

        cyc = 0;
        while (n[0] < 12 * 800 + 5 && cyc < BUDGET) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
        chk("run_complete", 32'(cyc < BUDGET), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_scan_engine.md
# vga_scan_engine

Raster engine for the 640x480@60 VGA output path. Generates the pixel coordinates, active-video flag and per-frame animation strobe consumed by the background and overlay generators. Composites the returned overlay pixel over the background pixel, and registers the result with sync pulses aligned to it. Sits at the top of the video pipeline, between the TinyTapeout pins and all pattern/overlay generators.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fg_draw  in  1  overlay pixel valid for current x/y
- fg_rgb  in  6  overlay colour
- bg_rgb  in  6  background colour
- x  out  10  horizontal counter, 0..H_TOTAL-1
- y  out  10  vertical counter, 0..V_TOTAL-1
- active  out  1  x<H_ACTIVE && y<V_ACTIVE
- next_frame  out  1  one-clk strobe at start of vertical blanking
- pix_tick  out  1  pixel-rate enable
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- rgb_out  out  6  registered composited pixel

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Counters are 10-bit unsigned.
- On pix_tick:
  - x increments; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps to 0 when x and y are both at their last value.
- active: combinational decode of registered x/y.
- Sync decode:
  - hsync asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vsync asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491.
  - Asserted level = SYNC_POL.
- next_frame = (x==0 && y==V_ACTIVE && pix_tick). Exactly one clk-cycle pulse per frame. Overlays advance animation state during blanking.
- Compositor: pixel = active ? (fg_draw ? fg_rgb : bg_rgb) : 6'b0. Overlay has priority; blanking forces black regardless of inputs.
- fg_draw, fg_rgb, bg_rgb must be combinational functions of the current x/y. They are sampled on the same pix_tick that advances the counters.

## Timing
- Reset values:
  - x=0, y=0
  - hsync=vsync=~SYNC_POL
  - rgb_out=0
  - next_frame=0
  - pix_tick = 0 with divider, 1 without
  - active=1 (decoded from 0,0)
- Latency: colour for coordinate (x,y) appears on rgb_out one pix_tick later. hsync/vsync pass through the same register stage, so sync and colour stay aligned.
- Outputs hold between pix_ticks.
- Reset mid-frame: counters return to (0,0) immediately. Output stage blanks asynchronously. First line after release is a full line.
- No handshake. Generators must settle within one pixel period.

## Configuration
- VGA_SCAN_PIXDIV_EN defined: clk runs at 2x pixel rate (50 MHz).
  - An internal toggle flop drives pix_tick: 0 at reset, then high on every second clk, the first one on the 2nd clk after reset release.
  - All counter and output-stage updates are gated by pix_tick.
  - next_frame remains a single clk-cycle pulse.
- Undefined: pix_tick tied to 1, and every clk is a pixel (25.175 MHz clk).

## Structure
- Shared package vga_timing_pkg:
  - 640x480 timing localparams and derived H_TOTAL/V_TOTAL
  - hsync/vsync start/end constants
  - 6-bit colour typedef and COLOR_BLACK
- Sub-module vga_axis_counter (parameter TOTAL): 10-bit wrapping counter with enable and wrap output. Instantiated twice, horizontal and vertical; the vertical instance is enabled by pix_tick && h_wrap.

## Test plan
- Reset release, run 800x525 pix_ticks -> x/y return to (0,0). Exactly one next_frame pulse, coinciding with x=0,y=480.
- Line scan -> hsync low for exactly 96 pix_ticks, first sampled low on the register stage after x=656. vsync low for exactly 2 lines, 490-491.
- fg_draw=1, fg_rgb=6'h3F, bg_rgb=6'h15 at x=10,y=10 -> rgb_out=6'h3F one pix_tick later. With fg_draw=0 -> 6'h15.
- x=700 (blanking), fg_draw=1, fg_rgb=6'h3F -> rgb_out=0.
- Assert rst at x=300,y=200 -> rgb_out=0 and sync deasserted immediately. After release, x,y count from (0,0).
- With VGA_SCAN_PIXDIV_EN: pix_tick alternates 0/1; x increments every 2 clk; next_frame is 1 clk wide; one frame = 840000 clk.
